// File: rtl/time_keeper.sv
// ============================================================================
// Module   : time_keeper
// Brief    : Wall-clock hour/minute/second keeper fed by a slow divided clock.
//            Optional alarm comparator under macro TIMEKEEPER_ALARM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_keeper #(
   parameter int EDGES_PER_SEC = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_in,
   input  logic       load_valid,
   input  logic [4:0] load_hour,
   input  logic [5:0] load_min,
   input  logic [5:0] load_sec,
   output logic       load_err,
   input  logic       alarm_arm,
   input  logic [4:0] alarm_hour,
   input  logic [5:0] alarm_min,
   output logic [4:0] hour,
   output logic [5:0] min,
   output logic [5:0] sec,
   output logic       sec_pulse,
   output logic       min_pulse,
   output logic       hour_pulse,
   output logic       alarm_fire
);

   localparam int              c_PW   = (EDGES_PER_SEC > 1) ? $clog2(EDGES_PER_SEC) : 1;
   localparam logic [c_PW-1:0] c_PMAX = c_PW'(EDGES_PER_SEC - 1);

   logic            r_s1, r_s2, r_s3;
   logic [c_PW-1:0] r_pcnt;
   logic [4:0]      r_hour;
   logic [5:0]      r_min, r_sec;
   logic            r_sec_pulse, r_min_pulse, r_hour_pulse, r_load_err;

   logic            w_edge, w_adv, w_load_ok, w_step;
   logic            w_sec_wrap, w_min_wrap, w_hour_wrap;
   logic [4:0]      w_hour_n;
   logic [5:0]      w_min_n, w_sec_n;

   assign w_edge      = r_s2 & ~r_s3;
   assign w_adv       = w_edge && (r_pcnt == c_PMAX);
   assign w_load_ok   = load_valid && (load_hour <= 5'd23) && (load_min <= 6'd59) && (load_sec <= 6'd59);
   // A valid load in the same cycle discards the advance entirely.
   assign w_step      = w_adv && !w_load_ok;

   assign w_sec_wrap  = (r_sec  == 6'd59);
   assign w_min_wrap  = (r_min  == 6'd59);
   assign w_hour_wrap = (r_hour == 5'd23);

   assign w_sec_n  = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
   assign w_min_n  = !w_sec_wrap ? r_min : (w_min_wrap ? 6'd0 : r_min + 6'd1);
   assign w_hour_n = !(w_sec_wrap && w_min_wrap) ? r_hour : (w_hour_wrap ? 5'd0 : r_hour + 5'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1         <= 1'b0;
         r_s2         <= 1'b0;
         r_s3         <= 1'b0;
         r_pcnt       <= '0;
         r_hour       <= '0;
         r_min        <= '0;
         r_sec        <= '0;
         r_sec_pulse  <= 1'b0;
         r_min_pulse  <= 1'b0;
         r_hour_pulse <= 1'b0;
         r_load_err   <= 1'b0;
      end else begin
         r_s1 <= tick_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         if (w_load_ok) begin
            r_hour <= load_hour;
            r_min  <= load_min;
            r_sec  <= load_sec;
            r_pcnt <= '0;
         end else begin
            if (w_edge)
               r_pcnt <= w_adv ? '0 : r_pcnt + c_PW'(1);
            if (w_step) begin
               r_hour <= w_hour_n;
               r_min  <= w_min_n;
               r_sec  <= w_sec_n;
            end
         end
         r_sec_pulse  <= w_step;
         r_min_pulse  <= w_step && w_sec_wrap;
         r_hour_pulse <= w_step && w_sec_wrap && w_min_wrap;
         r_load_err   <= load_valid && !w_load_ok;
      end
   end

`ifdef TIMEKEEPER_ALARM_EN
   logic r_alarm_fire;

   // Fires only on an advance that lands on hh:mm:00, never on a load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_alarm_fire <= 1'b0;
      else
         r_alarm_fire <= w_step && w_sec_wrap && alarm_arm &&
                         (w_min_n == alarm_min) && (w_hour_n == alarm_hour);
   end

   assign alarm_fire = r_alarm_fire;
`else
   logic w_unused_alarm;
   assign w_unused_alarm = ^{alarm_arm, alarm_hour, alarm_min};
   assign alarm_fire     = 1'b0;
`endif

   assign hour       = r_hour;
   assign min        = r_min;
   assign sec        = r_sec;
   assign sec_pulse  = r_sec_pulse;
   assign min_pulse  = r_min_pulse;
   assign hour_pulse = r_hour_pulse;
   assign load_err   = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_time_keeper.sv
// ============================================================================
// Module   : tb_time_keeper
// Brief    : Self-checking bench for time_keeper (EDGES_PER_SEC = 1 and 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_time_keeper;

   logic       clk = 1'b0;
   logic       rst, tick_in, load_valid, alarm_arm;
   logic [4:0] load_hour, alarm_hour;
   logic [5:0] load_min, load_sec, alarm_min;

   logic [4:0] hr  [2];
   logic [5:0] mn  [2];
   logic [5:0] sc  [2];
   logic       sp  [2];
   logic       mp  [2];
   logic       hp  [2];
   logic       er  [2];
   logic       af  [2];

   always #5 clk = ~clk;

   time_keeper #(.EDGES_PER_SEC(1)) u_dut1 (
      .clk(clk), .rst(rst), .tick_in(tick_in), .load_valid(load_valid),
      .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec), .load_err(er[0]),
      .alarm_arm(alarm_arm), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
      .hour(hr[0]), .min(mn[0]), .sec(sc[0]), .sec_pulse(sp[0]), .min_pulse(mp[0]),
      .hour_pulse(hp[0]), .alarm_fire(af[0]));

   time_keeper #(.EDGES_PER_SEC(4)) u_dut4 (
      .clk(clk), .rst(rst), .tick_in(tick_in), .load_valid(load_valid),
      .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec), .load_err(er[1]),
      .alarm_arm(alarm_arm), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
      .hour(hr[1]), .min(mn[1]), .sec(sc[1]), .sec_pulse(sp[1]), .min_pulse(mp[1]),
      .hour_pulse(hp[1]), .alarm_fire(af[1]));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: time of day as seconds since midnight.
   int eps  [2] = '{1, 4};
   int tod  [2];
   int pc   [2];
   bit e_sp [2], e_mp [2], e_hp [2], e_er [2], e_af [2];
   bit h1, h2, h3;
   int spc  [2], mpc [2], hpc [2], erc [2], afc [2];

   always @(posedge clk) begin
      if (rst) begin
         h1 = 0; h2 = 0; h3 = 0;
         for (int k = 0; k < 2; k++) begin
            tod[k] = 0; pc[k] = 0;
            e_sp[k] = 0; e_mp[k] = 0; e_hp[k] = 0; e_er[k] = 0; e_af[k] = 0;
         end
      end else begin
         bit ev, ok, adv, st;
         int nt;
         ev = h2 && !h3;
         h3 = h2; h2 = h1; h1 = tick_in;
         ok = load_valid && load_hour <= 23 && load_min <= 59 && load_sec <= 59;
         for (int k = 0; k < 2; k++) begin
            adv = ev && (pc[k] == eps[k] - 1);
            st  = adv && !ok;
            nt  = (tod[k] + 1) % 86400;
            e_sp[k] = st;
            e_mp[k] = st && (tod[k] % 60 == 59);
            e_hp[k] = st && (tod[k] % 3600 == 3599);
            e_er[k] = load_valid && !ok;
`ifdef TIMEKEEPER_ALARM_EN
            e_af[k] = st && alarm_arm && (nt % 60 == 0) && (nt / 3600 == int'(alarm_hour))
                      && ((nt / 60) % 60 == int'(alarm_min));
`else
            e_af[k] = 0;
`endif
            if (ok) begin
               tod[k] = load_hour * 3600 + load_min * 60 + load_sec;
               pc[k]  = 0;
            end else begin
               if (st) tod[k] = nt;
               if (ev) pc[k] = (pc[k] + 1) % eps[k];
            end
         end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("hour[%0d]", k), int'(hr[k]), tod[k] / 3600);
         chk($sformatf("min[%0d]", k), int'(mn[k]), (tod[k] / 60) % 60);
         chk($sformatf("sec[%0d]", k), int'(sc[k]), tod[k] % 60);
         chk($sformatf("sec_pulse[%0d]", k), int'(sp[k]), int'(e_sp[k]));
         chk($sformatf("min_pulse[%0d]", k), int'(mp[k]), int'(e_mp[k]));
         chk($sformatf("hour_pulse[%0d]", k), int'(hp[k]), int'(e_hp[k]));
         chk($sformatf("load_err[%0d]", k), int'(er[k]), int'(e_er[k]));
         chk($sformatf("alarm_fire[%0d]", k), int'(af[k]), int'(e_af[k]));
         if (sp[k]) spc[k]++;
         if (mp[k]) mpc[k]++;
         if (hp[k]) hpc[k]++;
         if (er[k]) erc[k]++;
         if (af[k]) afc[k]++;
      end
   end

   task automatic tick(input int hi, input int lo);
      tick_in = 1'b1;
      repeat (hi) @(negedge clk);
      tick_in = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic do_load(input int h, input int m, input int s);
      load_hour  = 5'(h);
      load_min   = 6'(m);
      load_sec   = 6'(s);
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_time(input string name, input int k, input int h, input int m, input int s);
      chk({name, "_hour"}, int'(hr[k]), h);
      chk({name, "_min"}, int'(mn[k]), m);
      chk({name, "_sec"}, int'(sc[k]), s);
   endtask

   int base_sp, base_af, fire_exp, hold;

   initial begin
      rst = 1'b1; tick_in = 1'b0; load_valid = 1'b0;
      load_hour = '0; load_min = '0; load_sec = '0;
      alarm_arm = 1'b0; alarm_hour = '0; alarm_min = '0;
      for (int k = 0; k < 2; k++) begin
         spc[k] = 0; mpc[k] = 0; hpc[k] = 0; erc[k] = 0; afc[k] = 0;
      end
      repeat (3) @(negedge clk);
      check_time("reset", 0, 0, 0, 0);
      chk("reset_sec_pulse", int'(sp[0]), 0);
      rst = 1'b0;
      @(negedge clk);

      // Three ticks from reset.
      repeat (3) tick(3, 3);
      repeat (4) @(negedge clk);
      check_time("three_ticks", 0, 0, 0, 3);
      chk("three_ticks_pulses", spc[0], 3);
      chk("three_ticks_eps4_sec", int'(sc[1]), 0);

      // Midnight rollover.
      do_load(23, 59, 58);
      base_sp = spc[0];
      repeat (2) tick(3, 3);
      repeat (4) @(negedge clk);
      check_time("rollover", 0, 0, 0, 0);
      chk("rollover_sec_pulses", spc[0] - base_sp, 2);
      chk("rollover_min_pulses", mpc[0], 1);
      chk("rollover_hour_pulses", hpc[0], 1);

      // Prescaler and its clear on load.
      do_load(0, 0, 0);
      repeat (7) tick(2, 2);
      repeat (4) @(negedge clk);
      chk("eps4_seven_ticks_sec", int'(sc[1]), 1);
      do_load(10, 0, 0);
      repeat (3) tick(2, 2);
      repeat (4) @(negedge clk);
      check_time("eps4_after_load", 1, 10, 0, 0);
      check_time("eps1_after_load", 0, 10, 0, 3);

      // Out-of-range load.
      do_load(24, 0, 0);
      @(negedge clk);
      chk("bad_load_err_count", erc[0], 1);
      check_time("bad_load_time", 0, 10, 0, 3);

      // Valid load colliding with an edge.
      base_sp = spc[0];
      tick_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      load_hour = 5'd5; load_min = 6'd6; load_sec = 6'd7; load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0; tick_in = 1'b0;
      repeat (4) @(negedge clk);
      check_time("collide", 0, 5, 6, 7);
      chk("collide_no_pulse", spc[0] - base_sp, 0);

      // Alarm.
      alarm_arm = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;
`ifdef TIMEKEEPER_ALARM_EN
      fire_exp = 1;
`else
      fire_exp = 0;
`endif
      do_load(7, 29, 59);
      base_af = afc[0];
      tick(3, 3);
      repeat (4) @(negedge clk);
      check_time("alarm_tick", 0, 7, 30, 0);
      chk("alarm_fire_count", afc[0] - base_af, fire_exp);
      do_load(7, 30, 0);
      repeat (3) @(negedge clk);
      chk("alarm_no_fire_on_load", afc[0] - base_af, fire_exp);

      // Reset with an edge in flight in the synchroniser.
      base_sp = spc[0];
      tick_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      tick_in = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check_time($sformatf("midreset%0d", k), k, 0, 0, 0);
         chk($sformatf("midreset_sec_pulse%0d", k), int'(sp[k]), 0);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("postreset_no_pulse", spc[0] - base_sp, 0);
      check_time("postreset", 0, 0, 0, 0);

      // Randomized traffic checked every cycle by the model.
      hold = 0;
      for (int i = 0; i < 4000; i++) begin
         hold++;
         if (hold >= 2 && $urandom_range(0, 2) == 0) begin
            tick_in = ~tick_in;
            hold = 0;
         end
         if ($urandom_range(0, 14) == 0) begin
            load_valid = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
               load_hour = alarm_hour;
               load_min  = alarm_min - 6'd1;
               load_sec  = 6'(56 + $urandom_range(0, 3));
            end else begin
               load_hour = 5'($urandom_range(0, 26));
               load_min  = 6'($urandom_range(0, 63));
               load_sec  = 6'($urandom_range(50, 62));
            end
         end else begin
            load_valid = 1'b0;
         end
         if ($urandom_range(0, 199) == 0) begin
            alarm_arm  = 1'($urandom_range(0, 1));
            alarm_hour = 5'($urandom_range(0, 23));
            alarm_min  = 6'($urandom_range(1, 59));
         end
         rst = ($urandom_range(0, 699) == 0);
         @(negedge clk);
      end
      rst = 1'b0; load_valid = 1'b0; tick_in = 1'b0;
      repeat (6) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/time_keeper.md
# time_keeper

Consumes the slow divided clock produced by the design's clock divider and turns it into wall-clock time for the alarm clock. The divided signal is treated as an asynchronous level input, synchronised into the fast `clk` domain, and edge-detected into one-cycle ticks. A prescaler turns ticks into seconds, and the block keeps hour/minute/second counters with a synchronous time-load port. An optional alarm comparator can be compiled in.

## Interface
- `EDGES_PER_SEC`, default 1: rising edges of `tick_in` per second (must be ≥1).
- `clk` in 1: system clock; the same clock that feeds the divider.
- `rst` in 1: asynchronous, active-high reset.
- `tick_in` in 1: divided slow clock, asynchronous to `clk`.
- `load_valid` in 1: one-cycle request to load time.
- `load_hour` in 5, `load_min` in 6, `load_sec` in 6: load values, binary.
- `load_err` out 1: one-cycle pulse when a load is rejected as out of range.
- `alarm_arm` in 1, `alarm_hour` in 5, `alarm_min` in 6: alarm setting.
- `hour` out 5 (0–23), `min` out 6 (0–59), `sec` out 6 (0–59): current time.
- `sec_pulse` out 1: one-cycle pulse on each second advance.
- `min_pulse` out 1, `hour_pulse` out 1: one-cycle pulses on minute and hour carry.
- `alarm_fire` out 1: one-cycle alarm pulse.

## Operation
- `tick_in` passes through a two-flop synchroniser (`s1`, `s2`) and then a history flop `s3`. `edge = s2 & ~s3`.
- Prescaler `pcnt` (width clog2(EDGES_PER_SEC), minimum 1 bit):
  - On `edge`: if `pcnt == EDGES_PER_SEC-1`, wrap to 0 and advance a second; otherwise increment.
- Second advance:
  - `sec` increments. At 59 it wraps to 0 and carries to `min`.
  - `min` at 59 wraps to 0 and carries to `hour`.
  - `hour` at 23 wraps to 0.
  - `sec_pulse`, `min_pulse` and `hour_pulse` are registered and asserted on the same edge as the corresponding counter update.
- Load:
  - When `load_valid` is high, range-check `load_hour ≤ 23`, `load_min ≤ 59`, `load_sec ≤ 59`.
  - Valid load: all three counters take the load values and `pcnt` clears to 0. No pulses are generated.
  - Invalid load: counters are unchanged and `load_err` pulses for one cycle.
- Simultaneous valid load and second advance: the load wins, the advance is discarded, and no `sec_pulse` is generated.
- Simultaneous invalid load and advance: the advance proceeds normally and `load_err` still pulses.
- Alarm (macro enabled only):
  - `alarm_fire` pulses on the edge where a second advance produces `sec == 0`, `min == alarm_min`, `hour == alarm_hour`, with `alarm_arm` high.
  - A load never fires the alarm, even if the loaded time matches.
- Arithmetic: all values are unsigned binary. No BCD.

## Timing
- Reset: `s1`, `s2`, `s3`, `pcnt`, `hour`, `min`, `sec`, all pulse outputs, `load_err` and `alarm_fire` are 0.
- Reset mid-operation clears all state immediately. The first edge after reset release requires `s2` to rise, so a `tick_in` already high at release produces one `edge` two cycles later.
- Latency: `tick_in` is first sampled high at clk edge E0. `s2` is high after E1. The counter update and `sec_pulse` appear after E2, i.e. they are visible in the cycle following E2.
- Load latency: the new time is visible in the cycle after the `load_valid` edge. `load_err` has the same latency.
- `tick_in` pulses must be at least 2 `clk` periods high and 2 low. Shorter pulses may be lost; this is not checked.
- Pulse outputs are never high for more than one consecutive cycle.

## Configuration
- Macro `TIMEKEEPER_ALARM_EN`.
- Defined: the alarm comparator is built and behaves as in Operation.
- Undefined: the comparator is removed. `alarm_fire` is tied to 0, and `alarm_arm`, `alarm_hour` and `alarm_min` remain as ports but are ignored. All other behaviour is identical.

## Test plan
- Reset then 3 `tick_in` rising edges, EDGES_PER_SEC=1 → `sec`=3, three `sec_pulse`s, each 3 clk edges after its `tick_in` rise.
- Load 23:59:58, then 2 ticks → `sec_pulse` ×2; on the second tick `min_pulse` and `hour_pulse` in the same cycle, time 00:00:00.
- EDGES_PER_SEC=4, 7 ticks → `sec`=1; then load 10:00:00 and 3 ticks → `sec`=0, because `pcnt` was cleared by the load.
- Load 24:00:00 → `load_err` one cycle, time unchanged. Valid load asserted in the same cycle as an `edge` → load value held, no `sec_pulse`.
- `TIMEKEEPER_ALARM_EN` defined, armed for 07:30, load 07:29:59, one tick → `alarm_fire` one cycle. Load 07:30:00 directly → no fire. Same tests without the macro → `alarm_fire` stays 0.
- Assert `rst` while the synchroniser holds an edge in flight → all outputs 0 next cycle, no spurious `sec_pulse` after release with `tick_in` low.
